// File: rtl/pool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : pool_pkg                                                       |
// | Purpose   : Shared defaults and FSM state encoding for the pooling-engine  |
// |             frame arbiter (62x62 input, 31x31 pooled output).              |
// | Contents  : DEF_* frame geometry / timing defaults, state_t enum.          |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package pool_pkg;

  localparam int DEF_PIX_W     = 12;
  localparam int DEF_IN_W      = 62;
  localparam int DEF_IN_H      = 62;
  localparam int DEF_OUT_PIX   = (DEF_IN_W / 2) * (DEF_IN_H / 2);
  localparam int DEF_CLEAR_CYC = 2;
  localparam int DEF_DRAIN_TMO = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pool_frame_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : pool_frame_arbiter_if                                          |
// | Purpose   : Bundles the two Sobel request streams and the pooling-engine   |
// |             input port that the frame arbiter sits between.               |
// | Modports  : slave  - arbiter side (accepts requests, drives engine)        |
// |             master - environment side (sources + engine)                   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface pool_frame_arbiter_if #(
  parameter int PIX_W = pool_pkg::DEF_PIX_W
);

  logic [PIX_W-1:0] req_pixel0;
  logic             req_valid0;
  logic             req_sof0;
  logic             req_ready0;
  logic [PIX_W-1:0] req_pixel1;
  logic             req_valid1;
  logic             req_sof1;
  logic             req_ready1;
  logic [PIX_W-1:0] pool_pixel;
  logic             pool_valid;
  logic             pool_ready;
  logic             pool_clear;
  logic             pool_out_valid;

  modport slave (
    input  req_pixel0, req_valid0, req_sof0,
    output req_ready0,
    input  req_pixel1, req_valid1, req_sof1,
    output req_ready1,
    output pool_pixel, pool_valid, pool_clear,
    input  pool_ready, pool_out_valid
  );

  modport master (
    output req_pixel0, req_valid0, req_sof0,
    input  req_ready0,
    output req_pixel1, req_valid1, req_sof1,
    input  req_ready1,
    input  pool_pixel, pool_valid, pool_clear,
    output pool_ready, pool_out_valid
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : rr_arb2                                                        |
// | Purpose   : Two-way round-robin arbiter. Combinational winner; the pointer |
// |             remembers the last winner and is loaded on 'update'.          |
// | Ports     : clk_200mhz, reset_n (async, active-low)                        |
// |             req[1:0] in, update in, gnt[1:0] one-hot out, winner out       |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arb2 (
  input  wire logic       clk_200mhz,
  input  wire logic       reset_n,
  input  wire logic [1:0] req,
  input  wire logic       update,
  output logic      [1:0] gnt,
  output logic            winner
);

  logic last;

  // On a tie the channel that did not win last time gets the grant.
  always_comb begin
    gnt    = 2'b00;
    winner = 1'b0;
    case (req)
      2'b01: begin gnt = 2'b01; winner = 1'b0; end
      2'b10: begin gnt = 2'b10; winner = 1'b1; end
      2'b11: begin
        winner = ~last;
        gnt    = last ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

  // Pointer resets to 1 so channel 0 wins the first tie.
  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n)
      last <= 1'b1;
    else if (update && (|req))
      last <= winner;
  end

endmodule
`default_nettype wire

// File: rtl/pool_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : pool_frame_arbiter                                             |
// | Purpose   : Frame-granular round-robin sequencer sharing one stride-2      |
// |             average-pooling engine between two Sobel pixel streams.       |
// |             Locks the grant for a whole frame, flushes the engine before  |
// |             each frame, forwards IN_W*IN_H pixels, counts pooled outputs. |
// | Ports     : clk_200mhz, reset_n (async, active-low)                        |
// |             bus        - request streams + engine port (slave modport)    |
// |             grant      - one-hot frame owner, 0 when idle                  |
// |             frame_done - 1-cycle end-of-frame pulse, frame_ch its channel |
// |             err_sof / err_count / err_timeout - sticky error flags         |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module pool_frame_arbiter import pool_pkg::*; #(
  parameter int PIX_W     = DEF_PIX_W,
  parameter int IN_W      = DEF_IN_W,
  parameter int IN_H      = DEF_IN_H,
  parameter int OUT_PIX   = DEF_OUT_PIX,
  parameter int CLEAR_CYC = DEF_CLEAR_CYC,
  parameter int DRAIN_TMO = DEF_DRAIN_TMO
) (
  input  wire logic            clk_200mhz,
  input  wire logic            reset_n,
  pool_frame_arbiter_if.slave  bus,
  output logic           [1:0] grant,
  output logic                 frame_done,
  output logic                 frame_ch,
  output logic                 err_sof,
  output logic                 err_count,
  output logic                 err_timeout
);

  localparam int N_PIX  = IN_W * IN_H;
  localparam int IN_CW  = $clog2(N_PIX + 1);
  localparam int OUT_CW = $clog2(OUT_PIX + 1) + 1;
  localparam int TMO_W  = $clog2(DRAIN_TMO + 1);
  localparam int CLR_W  = $clog2(CLEAR_CYC + 1);

  state_t              state, state_nxt;
  logic                owner;            // channel index of the locked frame
  logic [CLR_W-1:0]    clr_cnt;
  logic [IN_CW-1:0]    in_cnt;
  logic [OUT_CW-1:0]   out_cnt;
  logic [TMO_W-1:0]    tmo;

  logic [1:0]          sof_req;
  logic [1:0]          arb_gnt;
  logic                arb_win;
  logic                arb_update;
  logic                streaming;
  logic                sel_valid;
  logic                sel_sof;
  logic [PIX_W-1:0]    sel_pixel;
  logic                xfer;
  logic                out_full;

  // Only a valid start-of-frame pixel counts as a frame request.
  assign sof_req = {bus.req_valid1 & bus.req_sof1, bus.req_valid0 & bus.req_sof0};

  rr_arb2 u_rr_arb2 (
    .clk_200mhz (clk_200mhz),
    .reset_n    (reset_n),
    .req        (sof_req),
    .update     (arb_update),
    .gnt        (arb_gnt),
    .winner     (arb_win)
  );

  assign streaming = (state == STREAM);
  assign sel_valid = owner ? bus.req_valid1 : bus.req_valid0;
  assign sel_sof   = owner ? bus.req_sof1   : bus.req_sof0;
  assign sel_pixel = owner ? bus.req_pixel1 : bus.req_pixel0;

  assign bus.req_ready0 = grant[0] & streaming & bus.pool_ready;
  assign bus.req_ready1 = grant[1] & streaming & bus.pool_ready;
  assign bus.pool_valid = sel_valid & streaming;
  assign bus.pool_pixel = streaming ? sel_pixel : '0;
  assign bus.pool_clear = (state == CLEAR);

  assign xfer       = bus.pool_valid & bus.pool_ready;
  assign out_full   = (out_cnt == OUT_CW'(OUT_PIX));
  assign frame_done = (state == DONE);
  assign frame_ch   = frame_done & owner;

  always_comb begin
    state_nxt  = state;
    arb_update = 1'b0;
    case (state)
      IDLE: begin
        if (|sof_req) begin
          state_nxt  = CLEAR;
          arb_update = 1'b1;
        end
      end
      CLEAR:  if (clr_cnt == CLR_W'(CLEAR_CYC - 1)) state_nxt = STREAM;
      STREAM: if (xfer && (in_cnt == IN_CW'(N_PIX - 1))) state_nxt = DRAIN;
      DRAIN:  if (out_full || (tmo == TMO_W'(DRAIN_TMO))) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= 2'b00;
      owner       <= 1'b0;
      clr_cnt     <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      tmo         <= '0;
      err_sof     <= 1'b0;
      err_count   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_cnt <= '0;
          if (|sof_req) begin
            grant <= arb_gnt;
            owner <= arb_win;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          in_cnt  <= '0;
          out_cnt <= '0;
          tmo     <= '0;
        end
        STREAM: begin
          if (xfer) begin
            in_cnt <= in_cnt + 1'b1;
            // The opening sof is pixel 0; any later sof is a protocol error,
            // but the pixel is still forwarded so the frame stays aligned.
            if (sel_sof && (in_cnt != '0))
              err_sof <= 1'b1;
          end
        end
        DRAIN: begin
          if (!out_full) begin
            if (tmo == TMO_W'(DRAIN_TMO))
              err_timeout <= 1'b1;
            else
              tmo <= tmo + 1'b1;
          end
        end
        DONE: begin
          if (!out_full)
            err_count <= 1'b1;
          grant <= 2'b00;
        end
        default: ;
      endcase

      // Pooled outputs may still arrive while draining; counter saturates.
      if (((state == STREAM) || (state == DRAIN)) && bus.pool_out_valid && !(&out_cnt))
        out_cnt <= out_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_pool_frame_arbiter                                          |
// | Purpose   : Self-checking bench for pool_frame_arbiter: two frame sources, |
// |             a 2x2/stride-2 engine model, a pool-side monitor, a table of  |
// |             frame scenarios and hand sequences for latency / reset.        |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pool_frame_arbiter;

  localparam int PIX_W   = 12;
  localparam int IN_W    = 62;
  localparam int N_PIX   = 3844;
  localparam int OUT_PIX = 961;

  logic clk_200mhz = 1'b0;
  logic reset_n    = 1'b1;
  always #5 clk_200mhz = ~clk_200mhz;

  pool_frame_arbiter_if #(.PIX_W(PIX_W)) bus ();

  logic [1:0] grant;
  logic       frame_done, frame_ch, err_sof, err_count, err_timeout;

  pool_frame_arbiter #(.PIX_W(PIX_W)) dut (
    .clk_200mhz  (clk_200mhz),
    .reset_n     (reset_n),
    .bus         (bus),
    .grant       (grant),
    .frame_done  (frame_done),
    .frame_ch    (frame_ch),
    .err_sof     (err_sof),
    .err_count   (err_count),
    .err_timeout (err_timeout)
  );

  // ---------------- source / engine stimulus ----------------
  logic [PIX_W-1:0] px [2];
  logic             vld [2];
  logic             sof [2];
  logic             pool_ready_tb;
  logic             pov;

  assign bus.req_pixel0     = px[0];
  assign bus.req_valid0     = vld[0];
  assign bus.req_sof0       = sof[0];
  assign bus.req_pixel1     = px[1];
  assign bus.req_valid1     = vld[1];
  assign bus.req_sof1       = sof[1];
  assign bus.pool_ready     = pool_ready_tb;
  assign bus.pool_out_valid = pov;

  // control written only by the main process
  int freq [2];
  int sof_at1;
  int pr_mode;
  bit drop_en;
  int flush_req;

  // state written only by the cycle process
  int idx [2];
  int fsent [2];
  int flush_ack;
  bit xfer_q [2];
  int cyc;
  int tot_xfer, tot_outs, tot_clear, tot_ord, tot_viol, tot_done, tot_start;
  int done_ch [64];
  logic [1:0] start_grant [64];
  int pidx;
  bit prev_clear;

  int checks   = 0;
  int failures = 0;

  function automatic logic [PIX_W-1:0] pix_fn(input int ch, input int i);
    return PIX_W'((i * 7 + ch * 1365 + 3) & 4095);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Engine model: a pooled output follows every pixel at odd row and odd column.
  int eidx;
  always @(posedge clk_200mhz or negedge reset_n) begin
    if (!reset_n) begin
      eidx <= 0;
      pov  <= 1'b0;
    end else if (bus.pool_clear) begin
      eidx <= 0;
      pov  <= 1'b0;
    end else begin
      pov <= bus.pool_valid && pool_ready_tb && (((eidx / IN_W) % 2) == 1) &&
             (((eidx % IN_W) % 2) == 1) && !(drop_en && (eidx == N_PIX - 1));
      if (bus.pool_valid && pool_ready_tb) eidx <= eidx + 1;
    end
  end

  // Cycle process: drives sources at negedge, samples at negedge+1.
  initial begin : cycle_proc
    for (int c = 0; c < 2; c++) begin
      idx[c] = 0; fsent[c] = 0; xfer_q[c] = 1'b0;
      vld[c] = 1'b0; sof[c] = 1'b0; px[c] = '0;
    end
    flush_ack = 0; cyc = 0; pidx = 0; prev_clear = 1'b0;
    tot_xfer = 0; tot_outs = 0; tot_clear = 0; tot_ord = 0;
    tot_viol = 0; tot_done = 0; tot_start = 0;
    pool_ready_tb = 1'b1;
    forever begin
      @(negedge clk_200mhz);
      cyc++;
      for (int c = 0; c < 2; c++) begin
        if (xfer_q[c]) begin
          idx[c]++;
          if (idx[c] == N_PIX) begin
            idx[c] = 0;
            fsent[c]++;
          end
        end
      end
      if (flush_req != flush_ack) begin
        for (int c = 0; c < 2; c++) begin
          idx[c]   = 0;
          fsent[c] = freq[c];
        end
        flush_ack = flush_req;
      end
      pool_ready_tb = (pr_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      for (int c = 0; c < 2; c++) begin
        vld[c] = (fsent[c] < freq[c]);
        px[c]  = pix_fn(c, idx[c]);
        sof[c] = (idx[c] == 0) || ((c == 1) && (sof_at1 != 0) && (idx[c] == sof_at1));
      end
      #1;
      xfer_q[0] = vld[0] && bus.req_ready0;
      xfer_q[1] = vld[1] && bus.req_ready1;
      if ((bus.req_ready0 && !grant[0]) || (bus.req_ready1 && !grant[1]) ||
          ((bus.req_ready0 || bus.req_ready1) && !pool_ready_tb))
        tot_viol++;
      if (bus.pool_clear) begin
        tot_clear++;
        pidx = 0;
        if (!prev_clear) begin
          start_grant[tot_start % 64] = grant;
          tot_start++;
        end
      end
      prev_clear = bus.pool_clear;
      if (bus.pool_valid && pool_ready_tb) begin
        tot_xfer++;
        if (bus.pool_pixel !== pix_fn(grant[1] ? 1 : 0, pidx)) tot_ord++;
        pidx++;
      end
      if (pov) tot_outs++;
      if (frame_done) begin
        done_ch[tot_done % 64] = frame_ch ? 1 : 0;
        tot_done++;
      end
    end
  end

  // ---------------- scenario table ----------------
  typedef struct {
    int       add0;
    int       add1;
    int       pr;
    int       sofat1;
    bit       drop;
    int       nfr;
    bit [3:0] seq;      // expected channel of frame f in bit f
    bit       e_sof;
    bit       e_cnt;
    bit       e_tmo;
  } vec_t;

  vec_t vec [6];
  int b_x, b_o, b_c, b_ord, b_v, b_d, b_s;

  task automatic wait_done(input string name, input int target, input int budget);
    int n = 0;
    while ((tot_done < target) && (n < budget)) begin
      @(negedge clk_200mhz);
      n++;
    end
    chk(name, tot_done >= target, 1);
  endtask

  task automatic do_reset();
    int n = 0;
    @(negedge clk_200mhz); #2;
    reset_n = 1'b0;
    flush_req++;
    while ((flush_ack != flush_req) && (n < 10)) begin
      @(negedge clk_200mhz);
      n++;
    end
    repeat (2) @(negedge clk_200mhz);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic snap();
    b_x = tot_xfer; b_o = tot_outs; b_c = tot_clear; b_ord = tot_ord;
    b_v = tot_viol; b_d = tot_done; b_s = tot_start;
  endtask

  initial begin : main
    int n;
    freq[0] = 0; freq[1] = 0; sof_at1 = 0; pr_mode = 0; drop_en = 1'b0; flush_req = 0;

    vec[0] = '{1, 0, 0, 0,   1'b0, 1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vec[1] = '{1, 1, 0, 0,   1'b0, 2, 4'b0010, 1'b0, 1'b0, 1'b0};
    vec[2] = '{2, 2, 0, 0,   1'b0, 4, 4'b1010, 1'b0, 1'b0, 1'b0};
    vec[3] = '{1, 0, 1, 0,   1'b0, 1, 4'b0000, 1'b0, 1'b0, 1'b0};
    vec[4] = '{0, 1, 0, 100, 1'b0, 1, 4'b0001, 1'b1, 1'b0, 1'b0};
    vec[5] = '{1, 0, 0, 0,   1'b1, 1, 4'b0000, 1'b0, 1'b1, 1'b1};

    // reset state
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk_200mhz);
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_pool_valid", bus.pool_valid, 0);
    chk("rst_pool_clear", bus.pool_clear, 0);
    chk("rst_ready0", bus.req_ready0, 0);
    chk("rst_ready1", bus.req_ready1, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_errs", {err_sof, err_count, err_timeout}, 0);

    // IDLE -> CLEAR x2 -> STREAM turnaround
    reset_n = 1'b1;
    freq[0] = 1;
    @(negedge clk_200mhz); #2;
    chk("lat0_clear", bus.pool_clear, 0);
    chk("lat0_ready", bus.req_ready0, 0);
    @(negedge clk_200mhz); #2;
    chk("lat1_clear", bus.pool_clear, 1);
    chk("lat1_grant", grant, 2'b01);
    @(negedge clk_200mhz); #2;
    chk("lat2_clear", bus.pool_clear, 1);
    @(negedge clk_200mhz); #2;
    chk("lat3_clear", bus.pool_clear, 0);
    chk("lat3_ready", bus.req_ready0, 1);
    chk("lat3_valid", bus.pool_valid, 1);
    wait_done("lat_done_timeout", 1, 9000);

    // table of frame scenarios, each from a fresh reset
    for (int i = 0; i < 6; i++) begin
      do_reset();
      snap();
      pr_mode = vec[i].pr;
      sof_at1 = vec[i].sofat1;
      drop_en = vec[i].drop;
      freq[0] = freq[0] + vec[i].add0;
      freq[1] = freq[1] + vec[i].add1;
      wait_done($sformatf("v%0d_done_timeout", i), b_d + vec[i].nfr, vec[i].nfr * 9000 + 200);
      repeat (4) @(negedge clk_200mhz);
      #2;
      for (int f = 0; f < vec[i].nfr; f++) begin
        chk($sformatf("v%0d_f%0d_frame_ch", i, f), done_ch[(b_d + f) % 64], vec[i].seq[f]);
        chk($sformatf("v%0d_f%0d_grant", i, f), start_grant[(b_s + f) % 64],
            vec[i].seq[f] ? 2'b10 : 2'b01);
      end
      chk($sformatf("v%0d_xfers", i), tot_xfer - b_x, vec[i].nfr * N_PIX);
      chk($sformatf("v%0d_outs", i), tot_outs - b_o, vec[i].nfr * OUT_PIX - (vec[i].drop ? 1 : 0));
      chk($sformatf("v%0d_clear_cyc", i), tot_clear - b_c, 2 * vec[i].nfr);
      chk($sformatf("v%0d_pix_order", i), tot_ord - b_ord, 0);
      chk($sformatf("v%0d_ready_viol", i), tot_viol - b_v, 0);
      chk($sformatf("v%0d_err_sof", i), err_sof, vec[i].e_sof);
      chk($sformatf("v%0d_err_count", i), err_count, vec[i].e_cnt);
      chk($sformatf("v%0d_err_timeout", i), err_timeout, vec[i].e_tmo);
      chk($sformatf("v%0d_grant_idle", i), grant, 0);
    end

    // sticky errors survive into the next frame; async reset mid-STREAM clears them
    drop_en = 1'b0;
    snap();
    freq[0] = freq[0] + 1;
    n = 0;
    while ((tot_xfer < b_x + 500) && (n < 3000)) begin
      @(negedge clk_200mhz);
      n++;
    end
    chk("mr_reach_stream", tot_xfer >= b_x + 500, 1);
    #2;
    chk("mr_sticky_count", err_count, 1);
    chk("mr_sticky_tmo", err_timeout, 1);
    reset_n = 1'b0;
    #1;
    chk("mr_grant", grant, 0);
    chk("mr_pool_valid", bus.pool_valid, 0);
    chk("mr_ready0", bus.req_ready0, 0);
    chk("mr_errs", {err_sof, err_count, err_timeout}, 0);
    flush_req++;
    n = 0;
    while ((flush_ack != flush_req) && (n < 10)) begin
      @(negedge clk_200mhz);
      n++;
    end
    @(negedge clk_200mhz); #2;
    reset_n = 1'b1;
    snap();
    freq[0] = freq[0] + 1;
    wait_done("mr_done_timeout", b_d + 1, 9200);
    repeat (4) @(negedge clk_200mhz);
    #2;
    chk("mr_xfers", tot_xfer - b_x, N_PIX);
    chk("mr_outs", tot_outs - b_o, OUT_PIX);
    chk("mr_pix_order", tot_ord - b_ord, 0);
    chk("mr_frame_ch", done_ch[b_d % 64], 0);
    chk("mr_errs_after", {err_sof, err_count, err_timeout}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
